// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - main control FSM for the multicycle MIPS datapath
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   Opcode     IR[31:26]
//   Mem_Ready  memory completes the current access this cycle
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB, ALUOp, PCSrc, PCWrite   datapath selects and strobes
//   Beq, Bne   qualifiers for the external branch-condition logic
//   RegDst31   selects r31 as write register (MIPS_MC_JAL_EN only)
//   Illegal_Op sticky flag, set when an unsupported opcode is decoded
//
// Optional feature: define MIPS_MC_JAL_EN to support JAL (opcode 000011).
module mips_mc_control #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    Opcode,
  input  logic              Mem_Ready,
  output logic              IorD,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [1:0]        PCSrc,
  output logic              PCWrite,
  output logic              Beq,
  output logic              Bne,
`ifdef MIPS_MC_JAL_EN
  output logic              RegDst31,
`endif
  output logic              Illegal_Op
);

  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
`ifdef MIPS_MC_JAL_EN
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);
`endif

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
`ifdef MIPS_MC_JAL_EN
    ,JALWB = 4'd12
`endif
  } state_t;

  state_t     state, state_next;
  logic       set_illegal;
  logic       mem_write, ir_write, reg_write, pc_write, beq_q, bne_q;
  logic [1:0] alu_op;
`ifdef MIPS_MC_JAL_EN
  logic       reg_dst31;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      Illegal_Op <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) Illegal_Op <= 1'b1;
    end
  end

  always_comb begin
    state_next  = FETCH;
    set_illegal = 1'b0;
    IorD        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    reg_write   = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    PCSrc       = 2'b00;
    pc_write    = 1'b0;
    beq_q       = 1'b0;
    bne_q       = 1'b0;
`ifdef MIPS_MC_JAL_EN
    reg_dst31   = 1'b0;
`endif
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b01;
        ir_write   = Mem_Ready;
        pc_write   = Mem_Ready;
        state_next = Mem_Ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:   state_next = MEMADR;
          OP_RTYPE:       state_next = RTEX;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_ADDI:        state_next = ADDIEX;
          OP_J:           state_next = JUMP;
`ifdef MIPS_MC_JAL_EN
          OP_JAL: begin
            // Recompute PC+4 here so ALUOut keeps the link address for JALWB.
            ALUSrcB    = 2'b01;
            state_next = JALWB;
          end
`endif
          default: begin
            set_illegal = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD       = 1'b1;
        state_next = Mem_Ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
        state_next = Mem_Ready ? FETCH : MEMWR;
      end
      RTEX: begin
        ALUSrcA    = 1'b1;
        alu_op     = 2'b10;
        state_next = RTWB;
      end
      RTWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b01;
        PCSrc   = 2'b01;
        beq_q   = (Opcode == OP_BEQ);
        bne_q   = (Opcode == OP_BNE);
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MIPS_MC_JAL_EN
      JALWB: begin
        reg_write  = 1'b1;
        reg_dst31  = 1'b1;
        state_next = JUMP;
      end
`endif
      default: state_next = FETCH;
    endcase
  end

  // Strobes are gated by reset so nothing writes while reset is held,
  // even though FETCH would otherwise pass Mem_Ready through.
  assign MemWrite = reset & mem_write;
  assign IRWrite  = reset & ir_write;
  assign RegWrite = reset & reg_write;
  assign PCWrite  = reset & pc_write;
  assign Beq      = reset & beq_q;
  assign Bne      = reset & bne_q;
  assign ALUOp    = ALUOPW'(alu_op);
`ifdef MIPS_MC_JAL_EN
  assign RegDst31 = reg_dst31;
`endif

endmodule
